// File: rtl/wb_mem_arbiter.sv
// Three-master Wishbone arbiter in front of a single memory slave.
// Round-robin grant, whole-cycle ownership (bursts are never split), one
// dead cycle between owners, and a stalled-strobe watchdog that answers
// with a bus error when the slave stops responding.
module wb_mem_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_n_i,
  input  logic [2:0]          m_cyc_i,
  input  logic [2:0]          m_stb_i,
  input  logic [2:0]          m_we_i,
  input  logic [3*AW-1:0]     m_adr_i,
  input  logic [3*DW-1:0]     m_dat_i,
  input  logic [3*(DW/8)-1:0] m_sel_i,
  input  logic [8:0]          m_cti_i,
  input  logic [5:0]          m_bte_i,
  output logic [DW-1:0]       m_dat_o,
  output logic [2:0]          m_ack_o,
  output logic [2:0]          m_err_o,
  output logic [2:0]          m_rty_o,
  output logic                s_cyc_o,
  output logic                s_stb_o,
  output logic                s_we_o,
  output logic [AW-1:0]       s_adr_o,
  output logic [DW-1:0]       s_dat_o,
  output logic [DW/8-1:0]     s_sel_o,
  output logic [2:0]          s_cti_o,
  output logic [1:0]          s_bte_o,
  input  logic [DW-1:0]       s_dat_i,
  input  logic                s_ack_i,
  input  logic                s_err_i,
  input  logic                s_rty_i,
  output logic [2:0]          grant_o
);

  localparam int SW = DW / 8;
  // The error fires on the stalled cycle that would bring the count to TIMEOUT.
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  typedef enum logic {IDLE, OWNED} state_t;

  state_t      state_q, state_d;
  logic [1:0]  owner_q, owner_d;
  logic [1:0]  last_q, last_d;
  logic [15:0] wdog_q, wdog_d;
  logic        rdy_q, rdy_d;

  logic [AW-1:0] adr_arr [3];
  logic [DW-1:0] dat_arr [3];
  logic [SW-1:0] sel_arr [3];
  logic [2:0]    cti_arr [3];
  logic [1:0]    bte_arr [3];

  logic       owned;
  logic       own_cyc;
  logic       own_stb;
  logic       any_rsp;
  logic       stall;
  logic       timeout_hit;
  logic       win_vld;
  logic [1:0] win_idx;
  logic [1:0] cand;

  // Split the packed master buses into per-master lanes and route responses.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_master
      assign adr_arr[gi] = m_adr_i[gi*AW +: AW];
      assign dat_arr[gi] = m_dat_i[gi*DW +: DW];
      assign sel_arr[gi] = m_sel_i[gi*SW +: SW];
      assign cti_arr[gi] = m_cti_i[gi*3 +: 3];
      assign bte_arr[gi] = m_bte_i[gi*2 +: 2];

      assign grant_o[gi] = owned && (owner_q == 2'(gi));
      assign m_ack_o[gi] = grant_o[gi] && s_ack_i;
      assign m_rty_o[gi] = grant_o[gi] && s_rty_i;
      assign m_err_o[gi] = grant_o[gi] && (s_err_i || timeout_hit);
    end
  endgenerate

  assign owned   = (state_q == OWNED);
  assign own_cyc = m_cyc_i[owner_q];
  assign own_stb = m_stb_i[owner_q];
  assign any_rsp = s_ack_i || s_err_i || s_rty_i;
  // A slave response in the same cycle suppresses the timeout.
  assign stall       = owned && own_cyc && own_stb && !any_rsp;
  assign timeout_hit = stall && (wdog_q == TO_LAST);

  // Slave side is a straight mux of the owner's lanes, gated in IDLE.
  assign s_cyc_o = owned && own_cyc;
  assign s_stb_o = owned && own_cyc && own_stb && !timeout_hit;
  assign s_we_o  = m_we_i[owner_q];
  assign s_adr_o = adr_arr[owner_q];
  assign s_dat_o = dat_arr[owner_q];
  assign s_sel_o = sel_arr[owner_q];
  assign s_cti_o = cti_arr[owner_q];
  assign s_bte_o = bte_arr[owner_q];
  assign m_dat_o = s_dat_i;

  // Round-robin search starting just after the last owner.
  always_comb begin
    win_vld = 1'b0;
    win_idx = 2'd0;
    cand    = 2'd0;
    for (int k = 0; k < 3; k++) begin
      cand = 2'((int'(last_q) + 1 + k) % 3);
      if (!win_vld && m_cyc_i[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end

  // Next-state logic: grant from IDLE, release on owner cyc drop, watchdog.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    wdog_d  = wdog_q;
    rdy_d   = 1'b1;
    case (state_q)
      IDLE: begin
        wdog_d = '0;
        // rdy_q holds off arbitration on the first edge after reset release.
        if (rdy_q && win_vld) begin
          state_d = OWNED;
          owner_d = win_idx;
          last_d  = win_idx;
        end
      end
      OWNED: begin
        if (!own_cyc) begin
          state_d = IDLE;
        end
        if (stall && !timeout_hit) begin
          wdog_d = wdog_q + 16'd1;
        end else begin
          wdog_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset forces IDLE with master 0 first in line.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q <= IDLE;
      owner_q <= 2'd0;
      last_q  <= 2'd2;
      wdog_q  <= '0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      wdog_q  <= wdog_d;
      rdy_q   <= rdy_d;
    end
  end

endmodule

// File: tb/tb_wb_mem_arbiter.sv
// Self-checking bench for wb_mem_arbiter (TIMEOUT = 4): grant order, burst
// ownership, watchdog error, response precedence, reset mid-burst, write path.
module tb_wb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  m_cyc, m_stb, m_we;
  logic [95:0] m_adr, m_dat;
  logic [11:0] m_sel;
  logic [8:0]  m_cti;
  logic [5:0]  m_bte;
  logic [31:0] m_dat_o;
  logic [2:0]  m_ack_o, m_err_o, m_rty_o;
  logic        s_cyc_o, s_stb_o, s_we_o;
  logic [31:0] s_adr_o, s_dat_o;
  logic [3:0]  s_sel_o;
  logic [2:0]  s_cti_o;
  logic [1:0]  s_bte_o;
  logic [31:0] s_dat_i;
  logic        s_ack_i, s_err_i, s_rty_i;
  logic [2:0]  grant_o;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        we;
    logic [2:0]  grant;
  } txn_t;

  txn_t       sb_q [$];
  logic [2:0] grant_q [$];

  wb_mem_arbiter #(.AW(32), .DW(32), .TIMEOUT(4)) dut (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n),
    .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_we_i(m_we),
    .m_adr_i(m_adr), .m_dat_i(m_dat), .m_sel_i(m_sel),
    .m_cti_i(m_cti), .m_bte_i(m_bte),
    .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_rty_o(m_rty_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
    .s_cti_o(s_cti_o), .s_bte_o(s_bte_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i),
    .grant_o(grant_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_m(input int n, input logic cyc, input logic stb, input logic we,
                       input logic [31:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel, input logic [2:0] cti, input logic [1:0] bte);
    m_cyc[n] = cyc;
    m_stb[n] = stb;
    m_we[n]  = we;
    m_adr[n*32 +: 32] = adr;
    m_dat[n*32 +: 32] = dat;
    m_sel[n*4 +: 4]   = sel;
    m_cti[n*3 +: 3]   = cti;
    m_bte[n*2 +: 2]   = bte;
  endtask

  task automatic drop_all();
    m_cyc = 3'b000;
    m_stb = 3'b000;
    s_ack_i = 1'b0;
    s_err_i = 1'b0;
    s_rty_i = 1'b0;
    tick();
    tick();
  endtask

  // Reset held with all masters requesting and the slave answering.
  task automatic test_reset();
    rst_n = 1'b0;
    m_cyc = 3'b111; m_stb = 3'b111; m_we = 3'b000;
    m_adr = '0; m_dat = '0; m_sel = '0; m_cti = '0; m_bte = '0;
    s_dat_i = '0; s_ack_i = 1'b1; s_err_i = 1'b1; s_rty_i = 1'b1;
    tick();
    tick();
    checks++;
    if (grant_o !== 3'b000) begin failures++; $display("FAIL reset_grant: got %b expected 000", grant_o); end
    checks++;
    if ({s_cyc_o, s_stb_o} !== 2'b00) begin failures++; $display("FAIL reset_cyc_stb: got %b expected 00", {s_cyc_o, s_stb_o}); end
    checks++;
    if ({m_ack_o, m_err_o, m_rty_o} !== 9'b0) begin
      failures++; $display("FAIL reset_resp: got ack=%b err=%b rty=%b expected all 000", m_ack_o, m_err_o, m_rty_o);
    end
    s_ack_i = 1'b0; s_err_i = 1'b0; s_rty_i = 1'b0;
  endtask

  // All three request together out of reset: grants 001, 010, 100 with dead cycles.
  task automatic test_round_robin();
    logic [2:0] exp;
    int own;
    for (int n = 0; n < 3; n++) set_m(n, 1'b1, 1'b1, 1'b0, 32'h10 * (n + 1), '0, 4'hF, 3'b000, 2'b00);
    grant_q.push_back(3'b001);
    grant_q.push_back(3'b010);
    grant_q.push_back(3'b100);
    rst_n = 1'b1;
    tick();
    checks++;
    if (grant_o !== 3'b000) begin failures++; $display("FAIL rr_first_edge: got %b expected 000", grant_o); end
    for (int g = 0; g < 3; g++) begin
      tick();
      exp = grant_q.pop_front();
      own = (exp == 3'b001) ? 0 : (exp == 3'b010) ? 1 : 2;
      checks++;
      if (grant_o !== exp) begin failures++; $display("FAIL rr_grant%0d: got %b expected %b", g, grant_o, exp); end
      checks++;
      if (s_adr_o !== 32'h10 * (own + 1)) begin
        failures++; $display("FAIL rr_adr%0d: got %h expected %h", g, s_adr_o, 32'h10 * (own + 1));
      end
      s_ack_i = 1'b1;
      #1;
      checks++;
      if (m_ack_o !== exp) begin failures++; $display("FAIL rr_ack%0d: got %b expected %b", g, m_ack_o, exp); end
      $display("txn rr master=%0d adr=%h ack=%b", own, s_adr_o, m_ack_o);
      tick();
      s_ack_i = 1'b0;
      set_m(own, 1'b0, 1'b0, 1'b0, '0, '0, '0, 3'b000, 2'b00);
      tick();
      checks++;
      if (grant_o !== 3'b000) begin failures++; $display("FAIL rr_dead%0d: got %b expected 000", g, grant_o); end
    end
  endtask

  // Master 1 eight-beat burst while 0 and 2 wait; scoreboard holds beat addresses.
  task automatic test_burst();
    txn_t t;
    set_m(1, 1'b1, 1'b1, 1'b0, 32'h1000, '0, 4'hF, 3'b010, 2'b00);
    tick();
    checks++;
    if (grant_o !== 3'b010) begin failures++; $display("FAIL burst_grant: got %b expected 010", grant_o); end
    set_m(0, 1'b1, 1'b1, 1'b0, 32'hA0, '0, 4'hF, 3'b000, 2'b00);
    set_m(2, 1'b1, 1'b1, 1'b0, 32'hC0, '0, 4'hF, 3'b000, 2'b00);
    for (int b = 0; b < 8; b++) begin
      set_m(1, 1'b1, 1'b1, 1'b0, 32'h1000 + 32'(4 * b), '0, 4'hF, (b == 7) ? 3'b111 : 3'b010, 2'b00);
      sb_q.push_back('{adr: 32'h1000 + 32'(4 * b), dat: 32'h0, sel: 4'hF, we: 1'b0, grant: 3'b010});
      s_ack_i = 1'b1;
      #1;
      checks++;
      if (grant_o !== 3'b010) begin failures++; $display("FAIL burst_hold%0d: got %b expected 010", b, grant_o); end
      if (s_cyc_o && s_stb_o && s_ack_i && sb_q.size() > 0) begin
        t = sb_q.pop_front();
        $display("txn burst beat=%0d adr=%h cti=%b ack=%b", b, s_adr_o, s_cti_o, m_ack_o);
        checks++;
        if (s_adr_o !== t.adr) begin failures++; $display("FAIL burst_adr%0d: got %h expected %h", b, s_adr_o, t.adr); end
        checks++;
        if (m_ack_o !== t.grant) begin failures++; $display("FAIL burst_ack%0d: got %b expected %b", b, m_ack_o, t.grant); end
      end
      tick();
    end
    drop_all();
  endtask

  // Master 2 single read never acked: error on the 4th stalled cycle only.
  task automatic test_timeout();
    set_m(2, 1'b1, 1'b1, 1'b0, 32'h2000, '0, 4'hF, 3'b000, 2'b00);
    tick();
    checks++;
    if (grant_o !== 3'b100) begin failures++; $display("FAIL to_grant: got %b expected 100", grant_o); end
    for (int c = 1; c <= 5; c++) begin
      checks++;
      if (m_err_o !== ((c == 4) ? 3'b100 : 3'b000)) begin
        failures++; $display("FAIL to_err_c%0d: got %b expected %b", c, m_err_o, (c == 4) ? 3'b100 : 3'b000);
      end
      checks++;
      if (s_stb_o !== ((c == 4) ? 1'b0 : 1'b1)) begin
        failures++; $display("FAIL to_stb_c%0d: got %b expected %b", c, s_stb_o, (c == 4) ? 1'b0 : 1'b1);
      end
      if (c == 4) $display("txn timeout master=2 err=%b", m_err_o);
      tick();
    end
    drop_all();
  endtask

  // Ack on the 4th stalled cycle wins over the timeout; rty/err routing.
  task automatic test_timeout_ack();
    set_m(2, 1'b1, 1'b1, 1'b0, 32'h3000, '0, 4'hF, 3'b000, 2'b00);
    tick();
    for (int c = 1; c <= 3; c++) tick();
    s_ack_i = 1'b1;
    #1;
    checks++;
    if (m_ack_o !== 3'b100) begin failures++; $display("FAIL toack_ack: got %b expected 100", m_ack_o); end
    checks++;
    if (m_err_o !== 3'b000) begin failures++; $display("FAIL toack_err: got %b expected 000", m_err_o); end
    $display("txn late_ack master=2 ack=%b err=%b", m_ack_o, m_err_o);
    tick();
    s_ack_i = 1'b0;
    s_rty_i = 1'b1;
    #1;
    checks++;
    if ({m_rty_o, m_ack_o} !== 6'b100_000) begin failures++; $display("FAIL rty_route: got rty=%b ack=%b expected rty=100 ack=000", m_rty_o, m_ack_o); end
    s_rty_i = 1'b0;
    s_err_i = 1'b1;
    #1;
    checks++;
    if (m_err_o !== 3'b100) begin failures++; $display("FAIL err_route: got %b expected 100", m_err_o); end
    drop_all();
  endtask

  // Reset pulse during beat 3 of a master 0 burst; master 0 regrants first.
  task automatic test_reset_mid_burst();
    set_m(1, 1'b1, 1'b1, 1'b0, 32'h5000, '0, 4'hF, 3'b000, 2'b00);
    set_m(0, 1'b1, 1'b1, 1'b0, 32'h4000, '0, 4'hF, 3'b010, 2'b00);
    tick();
    checks++;
    if (grant_o !== 3'b001) begin failures++; $display("FAIL rst_burst_grant: got %b expected 001", grant_o); end
    for (int b = 0; b < 3; b++) begin
      set_m(0, 1'b1, 1'b1, 1'b0, 32'h4000 + 32'(4 * b), '0, 4'hF, 3'b010, 2'b00);
      s_ack_i = 1'b1;
      #1;
      checks++;
      if (m_ack_o !== 3'b001) begin failures++; $display("FAIL rst_burst_ack%0d: got %b expected 001", b, m_ack_o); end
      if (b < 2) tick();
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({grant_o, s_cyc_o, s_stb_o, m_ack_o, m_err_o, m_rty_o} !== 14'b0) begin
      failures++;
      $display("FAIL rst_async: got grant=%b cyc=%b stb=%b ack=%b err=%b rty=%b expected all zero",
               grant_o, s_cyc_o, s_stb_o, m_ack_o, m_err_o, m_rty_o);
    end
    tick();
    s_ack_i = 1'b0;
    rst_n = 1'b1;
    tick();
    checks++;
    if (grant_o !== 3'b000) begin failures++; $display("FAIL rst_release_edge1: got %b expected 000", grant_o); end
    tick();
    checks++;
    if (grant_o !== 3'b001) begin failures++; $display("FAIL rst_regrant: got %b expected 001", grant_o); end
    $display("txn reset_regrant grant=%b", grant_o);
    drop_all();
  endtask

  // Master 2 write: address/data/select passthrough and ack to master 2 only.
  task automatic test_write();
    txn_t t;
    set_m(0, 1'b0, 1'b0, 1'b0, 32'h11111111, 32'h22222222, 4'h3, 3'b001, 2'b10);
    set_m(1, 1'b0, 1'b0, 1'b0, 32'h33333333, 32'h44444444, 4'h5, 3'b010, 2'b11);
    set_m(2, 1'b1, 1'b1, 1'b1, 32'h00000100, 32'hDEADBEEF, 4'hF, 3'b111, 2'b01);
    sb_q.push_back('{adr: 32'h100, dat: 32'hDEADBEEF, sel: 4'hF, we: 1'b1, grant: 3'b100});
    tick();
    s_dat_i = 32'hCAFEF00D;
    s_ack_i = 1'b1;
    #1;
    checks++;
    if (sb_q.size() == 0) begin
      failures++; $display("FAIL wr_sb: got empty queue expected 1 entry");
    end else begin
      t = sb_q.pop_front();
      $display("txn write adr=%h dat=%h sel=%h we=%b ack=%b", s_adr_o, s_dat_o, s_sel_o, s_we_o, m_ack_o);
      checks++;
      if (s_adr_o !== t.adr) begin failures++; $display("FAIL wr_adr: got %h expected %h", s_adr_o, t.adr); end
      checks++;
      if (s_dat_o !== t.dat) begin failures++; $display("FAIL wr_dat: got %h expected %h", s_dat_o, t.dat); end
      checks++;
      if (s_sel_o !== t.sel) begin failures++; $display("FAIL wr_sel: got %h expected %h", s_sel_o, t.sel); end
      checks++;
      if ({s_we_o, s_cyc_o, s_stb_o} !== {t.we, 2'b11}) begin failures++; $display("FAIL wr_ctl: got %b expected %b", {s_we_o, s_cyc_o, s_stb_o}, {t.we, 2'b11}); end
      checks++;
      if (m_ack_o !== t.grant) begin failures++; $display("FAIL wr_ack: got %b expected %b", m_ack_o, t.grant); end
    end
    checks++;
    if ({s_cti_o, s_bte_o} !== 5'b111_01) begin failures++; $display("FAIL wr_cti_bte: got %b expected 11101", {s_cti_o, s_bte_o}); end
    checks++;
    if (m_dat_o !== 32'hCAFEF00D) begin failures++; $display("FAIL rd_dat: got %h expected cafef00d", m_dat_o); end
    drop_all();
    checks++;
    if (sb_q.size() != 0) begin failures++; $display("FAIL sb_leftover: got %0d expected 0", sb_q.size()); end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_burst();
    test_timeout();
    test_timeout_ack();
    test_reset_mid_burst();
    test_write();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_mem_arbiter.md
WB_MEM_ARBITER -- requirements
Module: wb_mem_arbiter

Interface
REQ-001 SHALL have parameter AW, default 32, address width.
REQ-002 SHALL have parameter DW, default 32, data width.
REQ-003 SHALL have parameter TIMEOUT, default 255, stalled-cycle limit before bus error (range 2..65535).
REQ-004 SHALL have ports as follows; master index 0 = CPU instruction bus, 1 = CPU data bus, 2 = debug master.
- wb_clk_i  in  1  sole clock; all state on rising edge.
- wb_rst_n_i  in  1  reset; one clock, asynchronous, active-low.
- m_cyc_i  in  3  per-master cycle.
- m_stb_i  in  3  per-master strobe.
- m_we_i  in  3  per-master write enable.
- m_adr_i  in  3*AW  packed addresses; master n at [n*AW +: AW].
- m_dat_i  in  3*DW  packed write data.
- m_sel_i  in  3*DW/8  packed byte selects.
- m_cti_i  in  9  packed cycle type, 3 bits per master.
- m_bte_i  in  6  packed burst type, 2 bits per master.
- m_dat_o  out  DW  read data, broadcast to all masters.
- m_ack_o  out  3  per-master ack.
- m_err_o  out  3  per-master error.
- m_rty_o  out  3  per-master retry.
- s_cyc_o, s_stb_o, s_we_o  out  1 each  slave controls.
- s_adr_o  out  AW  slave address.
- s_dat_o  out  DW  slave write data.
- s_sel_o  out  DW/8  slave byte selects.
- s_cti_o  out  3  slave cycle type.
- s_bte_o  out  2  slave burst type.
- s_dat_i  in  DW  slave read data.
- s_ack_i, s_err_i, s_rty_i  in  1 each  slave responses.
- grant_o  out  3  one-hot current owner, 000 when idle.

Function
REQ-005 SHALL implement FSM with states IDLE and OWNED; owner held in a 2-bit register; last-owner register for round-robin.
REQ-006 IDLE: if any m_cyc_i set, SHALL register winner and enter OWNED next cycle; arbitration latency exactly 1 cycle.
REQ-007 Winner SHALL be first requesting master searching from (last_owner+1) mod 3 upward with wrap; last_owner updated on grant.
REQ-008 OWNED: owner held while its m_cyc_i = 1, regardless of other requests, so bursts (cti 001/010) are never split.
REQ-009 OWNED: when owner's m_cyc_i = 0, SHALL return to IDLE next cycle; new grant no earlier than the cycle after that (one dead cycle between owners).
REQ-010 s_* outputs SHALL be combinational mux of owner's signals; s_cyc_o and s_stb_o SHALL be 0 in IDLE.
REQ-011 s_ack_i/s_err_i/s_rty_i SHALL be routed combinationally only to owner's m_*_o bit; non-owners always see 0.
REQ-012 m_dat_o SHALL equal s_dat_i unconditionally.
REQ-013 Watchdog: 16-bit counter increments each OWNED cycle with s_stb_o = 1 and no s_ack_i/s_err_i/s_rty_i; clears on any response, on owner stb = 0, and in IDLE.
REQ-014 When counter reaches TIMEOUT, SHALL assert m_err_o[owner] for exactly 1 cycle, force s_stb_o = 0 that cycle, clear counter; ownership persists until owner drops cyc.
REQ-015 A slave response in the same cycle as timeout SHALL take precedence; no error is generated.
REQ-016 grant_o SHALL be one-hot of owner in OWNED, 000 in IDLE.

Reset
REQ-017 Asserting wb_rst_n_i low SHALL immediately force IDLE, owner = 0, last_owner = 2 (master 0 wins first), counter = 0, grant_o = 000, s_cyc_o = s_stb_o = 0, all m_ack_o/m_err_o/m_rty_o = 0, including mid-burst.
REQ-018 After reset release, first grant SHALL occur no earlier than the second rising edge.

Verification
REQ-019 All three cyc raised together after reset -> grant order 0,1,2; each grant follows 1 dead IDLE cycle; grant_o 001,010,100.
REQ-020 Master 1 runs 8-beat incrementing burst (cti 010 ... 111) while masters 0 and 2 request -> all 8 acks to master 1 only; grant_o stays 010 throughout.
REQ-021 TIMEOUT = 4, slave never acks master 2 single read -> m_err_o = 100 for one cycle on 4th stalled cycle; s_stb_o low that cycle.
REQ-022 TIMEOUT = 4, s_ack_i arrives on the 4th stalled cycle -> m_ack_o[owner] = 1, m_err_o = 000.
REQ-023 wb_rst_n_i pulsed low during beat 3 of a master 0 burst -> outputs zero asynchronously; after release master 0 regrants first.
REQ-024 Master 2 write, dat 0xDEADBEEF, sel 0xF, adr 0x00000100 -> s_adr_o/s_dat_o/s_sel_o match; only m_ack_o[2] pulses.
